dma_service_arbiter: RTL and testbench
======================================

DMA_SERVICE_ARBITER -- requirements
Module: dma_service_arbiter

Interface
REQ-001 Parameter HLDA_TIMEOUT, default 0: cycles to wait in HOLD_REQ for HLDA before abandoning; 0 = wait forever.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 Reset_n  in  1  asynchronous, active-low reset.
REQ-004 DREQ  in  4  hardware channel requests; sense set by COMMAND[6].
REQ-005 HLDA  in  1  hold acknowledge from CPU.
REQ-006 TC  in  1  terminal count from address/count datapath, one-cycle pulse.
REQ-007 MASK  in  4  1 = channel n hardware request masked.
REQ-008 REQUEST  in  4  software request: [2] valid, [1:0] channel.
REQ-009 COMMAND  in  8  [2] controller disable, [4] rotating priority, [6] DREQ active-low when 1.
REQ-010 HRQ  out  1  hold request to CPU.
REQ-011 DACK  out  4  one-hot active-high channel acknowledge.
REQ-012 grant_ch  out  2  index of serviced channel; selects ch0..ch3 in the datapath mux.
REQ-013 busy  out  1  high in HOLD_REQ, ACTIVE, RELEASE.
REQ-014 sw_done  out  1  one-cycle pulse when a software-requested service ends on TC.

Function
REQ-015 The block SHALL form pending[3:0] = (DREQ xor {4{COMMAND[6]}}) & ~MASK, OR'd with the decoded channel bit when REQUEST[2]=1 (software request ignores MASK).
REQ-016 The FSM SHALL have states IDLE, HOLD_REQ, ACTIVE, RELEASE.
REQ-017 IDLE: pending!=0 and COMMAND[2]=0 -> HOLD_REQ; HRQ=1 registered on that edge.
REQ-018 HOLD_REQ: HLDA=1 -> ACTIVE; pending==0 -> IDLE with HRQ=0; HLDA_TIMEOUT>0 and wait counter reaches HLDA_TIMEOUT -> RELEASE.
REQ-019 The winner SHALL be chosen on the HOLD_REQ->ACTIVE edge from pending at that cycle; software request beats any hardware request.
REQ-020 Hardware priority: fixed 0>1>2>3 when COMMAND[4]=0; rotating when COMMAND[4]=1, where the last serviced channel becomes lowest.
REQ-021 DACK[winner] and grant_ch SHALL be valid the cycle after HLDA is sampled high (latency 1) and stay stable throughout ACTIVE.
REQ-022 ACTIVE exits to RELEASE on: TC=1, the granted channel's pending bit falling, or HLDA=0; simultaneous causes SHALL produce one RELEASE.
REQ-023 RELEASE SHALL last exactly one cycle with HRQ=0, DACK=0, then go to IDLE.
REQ-024 The rotation pointer SHALL update on ACTIVE->RELEASE only, and only for hardware grants.
REQ-025 sw_done SHALL pulse in RELEASE iff the grant was software-originated and TC caused the exit.
REQ-026 COMMAND[2]=1 while busy SHALL force RELEASE next cycle; no new HOLD_REQ while set.
REQ-027 DACK SHALL never have more than one bit set.

Reset
REQ-028 Reset_n low SHALL asynchronously force IDLE, HRQ=0, DACK=4'b0000, grant_ch=0, busy=0, sw_done=0, wait counter 0, rotation pointer so channel 0 is highest.
REQ-029 Reset mid-ACTIVE SHALL drop DACK and HRQ immediately, without passing through RELEASE.

Configuration
REQ-030 Macro DMA_ROTATE_PRIO_EN defined: rotating priority per REQ-020 is built; undefined: pointer logic is omitted, priority is always fixed 0>1>2>3, COMMAND[4] is ignored.

Structure
REQ-031 Shared package dma_pkg SHALL hold the state enum, the 2-bit channel index type, and COMMAND bit-position constants.
REQ-032 Sub-module dma_prio_encoder (pending, rotation pointer -> one-hot winner and index) SHALL be the only arbitration logic.

Verification
REQ-033 DREQ=4'b1010, MASK=0, COMMAND=0; HLDA high 3 cycles after HRQ -> DACK=4'b0010, grant_ch=1 one cycle after HLDA sampled; TC pulse -> RELEASE, then HRQ re-asserts for ch3.
REQ-034 COMMAND[4]=1, DREQ=4'b1111 held, TC after each grant -> grant order 0,1,2,3,0.
REQ-035 REQUEST=3'b110 with DREQ=4'b0001 -> ch2 granted first; TC -> sw_done pulses once.
REQ-036 HLDA_TIMEOUT=4, DREQ0 held, HLDA never high -> HRQ high 4 cycles, RELEASE, then HRQ re-asserts.
REQ-037 Reset_n low during ACTIVE with DACK=4'b0100 -> DACK=0, HRQ=0 without waiting for clk; after release, first grant follows fixed order from ch0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA service arbiter.
// FSM state encoding, channel index type, COMMAND bit positions.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_REQ = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_RELEASE  = 2'd3
  } dma_state_e;

  typedef logic [1:0] dma_ch_t;

  localparam int CMD_DIS     = 2;
  localparam int CMD_ROT     = 4;
  localparam int CMD_DREQ_LO = 6;

endpackage

// File: rtl/dma_prio_encoder.sv
// Four-way priority encoder; ptr_i names the highest-priority channel,
// priority then descends ptr_i, ptr_i+1, ... modulo 4.
module dma_prio_encoder
  import dma_pkg::*;
(
  input  logic    [3:0] pend_i,
  input  dma_ch_t       ptr_i,
  output logic    [3:0] win_oh_o,
  output dma_ch_t       win_idx_o,
  output logic          win_vld_o
);

  dma_ch_t ch;

  // Scan lowest priority first so the highest pending channel wins last
  always_comb begin
    ch        = '0;
    win_idx_o = '0;
    win_vld_o = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      ch = ptr_i + dma_ch_t'(i);
      if (pend_i[ch]) begin
        win_idx_o = ch;
        win_vld_o = 1'b1;
      end
    end
    win_oh_o = win_vld_o ? (4'b0001 << win_idx_o) : 4'b0000;
  end

endmodule

// File: rtl/dma_service_arbiter.sv
// DMA channel service arbiter: HRQ/HLDA handshake and one-hot DACK.
// Define DMA_ROTATE_PRIO_EN to build rotating priority (COMMAND[4]).
module dma_service_arbiter
  import dma_pkg::*;
#(
  parameter int unsigned HLDA_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic [3:0] DREQ,
  input  logic       HLDA,
  input  logic       TC,
  input  logic [3:0] MASK,
  input  logic [2:0] REQUEST,
  input  logic [7:0] COMMAND,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic [1:0] grant_ch,
  output logic       busy,
  output logic       sw_done
);

  localparam int WW =
    (HLDA_TIMEOUT > 1) ? $clog2(HLDA_TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TO_VAL = WW'(HLDA_TIMEOUT);
  localparam bit TO_EN = (HLDA_TIMEOUT != 0);

  dma_state_e    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d, wait_nxt;
  logic [3:0]    dack_q, dack_d;
  dma_ch_t       grant_q, grant_d;
  logic          sw_q, sw_d;
  logic          sw_done_q, sw_done_d;

  logic [3:0] hw_pend, sw_vec, pending, arb_in;
  logic [3:0] win_oh;
  dma_ch_t    win_idx;
  dma_ch_t    enc_ptr;
  logic       win_vld;
  logic       exit_act;

  // Request qualification; software request bypasses MASK
  always_comb begin
    hw_pend = (DREQ ^ {4{COMMAND[CMD_DREQ_LO]}}) & ~MASK;
    sw_vec  = REQUEST[2] ? (4'b0001 << REQUEST[1:0]) : 4'b0000;
    pending = hw_pend | sw_vec;
    arb_in  = REQUEST[2] ? sw_vec : hw_pend;
  end

  dma_prio_encoder u_prio (
    .pend_i    (arb_in),
    .ptr_i     (enc_ptr),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .win_vld_o (win_vld)
  );

`ifdef DMA_ROTATE_PRIO_EN
  dma_ch_t ptr_q, ptr_d;
  logic    ptr_upd;

  assign enc_ptr = COMMAND[CMD_ROT] ? ptr_q : '0;
  assign ptr_upd = (state_q == ST_ACTIVE) && exit_act && !sw_q;

  // Channel after the last hardware grant becomes highest priority
  always_comb begin
    ptr_d = ptr_q;
    if (ptr_upd) ptr_d = grant_q + 2'd1;
  end

  // Rotation pointer register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  logic unused_cmd;
  assign unused_cmd =
    ^{COMMAND[7], COMMAND[5], COMMAND[3], COMMAND[1:0]};
`else
  assign enc_ptr = '0;

  logic unused_cmd;
  assign unused_cmd =
    ^{COMMAND[7], COMMAND[5:3], COMMAND[1:0]};
`endif

  assign wait_nxt = wait_q + 1'b1;
  assign exit_act = TC || !pending[grant_q] || !HLDA ||
                    COMMAND[CMD_DIS];

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    dack_d    = dack_q;
    grant_d   = grant_q;
    sw_d      = sw_q;
    sw_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if ((|pending) && !COMMAND[CMD_DIS])
          state_d = ST_HOLD_REQ;
      end
      ST_HOLD_REQ: begin
        if (COMMAND[CMD_DIS]) begin
          state_d = ST_RELEASE;
        end else if (pending == 4'b0000) begin
          state_d = ST_IDLE;
        end else if (HLDA && win_vld) begin
          state_d = ST_ACTIVE;
          dack_d  = win_oh;
          grant_d = win_idx;
          sw_d    = REQUEST[2];
        end else if (TO_EN && (wait_nxt == TO_VAL)) begin
          state_d = ST_RELEASE;
        end else begin
          wait_d = wait_nxt;
        end
      end
      ST_ACTIVE: begin
        if (exit_act) begin
          state_d   = ST_RELEASE;
          dack_d    = 4'b0000;
          sw_done_d = sw_q && TC;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        wait_d  = '0;
        sw_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      dack_q    <= 4'b0000;
      grant_q   <= '0;
      sw_q      <= 1'b0;
      sw_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      dack_q    <= dack_d;
      grant_q   <= grant_d;
      sw_q      <= sw_d;
      sw_done_q <= sw_done_d;
    end
  end

  assign HRQ      = (state_q == ST_HOLD_REQ) ||
                    (state_q == ST_ACTIVE);
  assign busy     = (state_q != ST_IDLE);
  assign DACK     = dack_q;
  assign grant_ch = grant_q;
  assign sw_done  = sw_done_q;

endmodule

// File: tb/tb_dma_service_arbiter.sv
// Directed self-checking bench for dma_service_arbiter.
// Second instance exercises the HLDA timeout with HLDA held low.
module tb_dma_service_arbiter;

  logic       clk;
  logic       Reset_n;
  logic [3:0] DREQ;
  logic       HLDA;
  logic       TC;
  logic [3:0] MASK;
  logic [2:0] REQUEST;
  logic [7:0] COMMAND;
  logic       HRQ, busy, sw_done;
  logic [3:0] DACK;
  logic [1:0] grant_ch;

  logic       hlda2;
  logic       hrq2, busy2, sw_done2;
  logic [3:0] dack2;
  logic [1:0] grant2;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] rot_seq [5];

  dma_service_arbiter #(.HLDA_TIMEOUT(0)) dut (
    .clk(clk), .Reset_n(Reset_n), .DREQ(DREQ), .HLDA(HLDA),
    .TC(TC), .MASK(MASK), .REQUEST(REQUEST), .COMMAND(COMMAND),
    .HRQ(HRQ), .DACK(DACK), .grant_ch(grant_ch), .busy(busy),
    .sw_done(sw_done)
  );

  dma_service_arbiter #(.HLDA_TIMEOUT(4)) dut_to (
    .clk(clk), .Reset_n(Reset_n), .DREQ(DREQ), .HLDA(hlda2),
    .TC(TC), .MASK(MASK), .REQUEST(REQUEST), .COMMAND(COMMAND),
    .HRQ(hrq2), .DACK(dack2), .grant_ch(grant2), .busy(busy2),
    .sw_done(sw_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
`ifdef DMA_ROTATE_PRIO_EN
    rot_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    rot_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    hlda2 = 1'b0;
    Reset_n = 1'b0; DREQ = 4'h0; HLDA = 1'b0; TC = 1'b0;
    MASK = 4'h0; REQUEST = 3'b000; COMMAND = 8'h00;
    #3;
    chk("rst_hrq", {7'd0, HRQ}, 8'd0);
    chk("rst_dack", {4'd0, DACK}, 8'd0);
    chk("rst_grant", {6'd0, grant_ch}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_swdone", {7'd0, sw_done}, 8'd0);
    @(posedge clk); #1;
    Reset_n = 1'b1;

    // Basic grant with delayed HLDA, then ch3 follows
    DREQ = 4'b1010;
    tick(); chk("a_hrq1", {7'd0, HRQ}, 8'd1);
    chk("a_dack_hold", {4'd0, DACK}, 8'd0);
    tick(); chk("a_hrq2", {7'd0, HRQ}, 8'd1);
    tick(); chk("a_hrq3", {7'd0, HRQ}, 8'd1);
    HLDA = 1'b1;
    tick(); chk("a_dack1", {4'd0, DACK}, 8'b0010);
    chk("a_grant1", {6'd0, grant_ch}, 8'd1);
    tick(); chk("a_dack_stable", {4'd0, DACK}, 8'b0010);
    TC = 1'b1;
    tick(); TC = 1'b0;
    chk("a_rel_hrq", {7'd0, HRQ}, 8'd0);
    chk("a_rel_dack", {4'd0, DACK}, 8'd0);
    chk("a_rel_busy", {7'd0, busy}, 8'd1);
    DREQ = 4'b1000;
    tick(); chk("a_idle_busy", {7'd0, busy}, 8'd0);
    tick(); chk("a_hrq_ch3", {7'd0, HRQ}, 8'd1);
    tick(); chk("a_dack3", {4'd0, DACK}, 8'b1000);
    chk("a_grant3", {6'd0, grant_ch}, 8'd3);
    DREQ = 4'b0000;
    tick(); chk("a_drop_dack", {4'd0, DACK}, 8'd0);
    chk("a_drop_swdone", {7'd0, sw_done}, 8'd0);
    tick(); chk("a_drop_idle", {7'd0, busy}, 8'd0);

    // Rotating priority sequence (fixed 0 when feature absent)
    COMMAND = 8'h10; DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("r_hrq", {7'd0, HRQ}, 8'd1);
      tick(); chk("r_grant", {6'd0, grant_ch}, {6'd0, rot_seq[i]});
      chk("r_dack", {4'd0, DACK}, 8'd1 << rot_seq[i]);
      TC = 1'b1;
      tick(); TC = 1'b0;
      chk("r_rel_dack", {4'd0, DACK}, 8'd0);
      tick();
    end
    DREQ = 4'h0; COMMAND = 8'h00;
    tick();

    // Active-low DREQ sense, MASK, controller disable
    COMMAND = 8'h40; DREQ = 4'b1100; MASK = 4'b0001;
    tick(); chk("m_hrq", {7'd0, HRQ}, 8'd1);
    tick(); chk("m_grant", {6'd0, grant_ch}, 8'd1);
    chk("m_dack", {4'd0, DACK}, 8'b0010);
    COMMAND = 8'h44;
    tick(); chk("d_rel_hrq", {7'd0, HRQ}, 8'd0);
    chk("d_rel_busy", {7'd0, busy}, 8'd1);
    tick(); chk("d_idle", {7'd0, busy}, 8'd0);
    tick(); chk("d_no_hold", {7'd0, HRQ}, 8'd0);
    COMMAND = 8'h00; DREQ = 4'h0; MASK = 4'h0;
    tick();

    // Software request beats hardware and ignores MASK
    DREQ = 4'b0001; REQUEST = 3'b110; MASK = 4'b0100;
    tick(); chk("s_hrq", {7'd0, HRQ}, 8'd1);
    tick(); chk("s_dack", {4'd0, DACK}, 8'b0100);
    chk("s_grant", {6'd0, grant_ch}, 8'd2);
    TC = 1'b1;
    tick(); TC = 1'b0;
    chk("s_done", {7'd0, sw_done}, 8'd1);
    chk("s_rel_dack", {4'd0, DACK}, 8'd0);
    REQUEST = 3'b000; MASK = 4'h0;
    tick(); chk("s_done_once", {7'd0, sw_done}, 8'd0);
    tick(); chk("s_hw_hrq", {7'd0, HRQ}, 8'd1);
    tick(); chk("s_hw_dack", {4'd0, DACK}, 8'b0001);
    TC = 1'b1;
    tick(); TC = 1'b0;
    chk("s_hw_nodone", {7'd0, sw_done}, 8'd0);
    DREQ = 4'h0;
    tick();

    // HLDA timeout on second instance; first waits forever
    Reset_n = 1'b0; #2; Reset_n = 1'b1;
    DREQ = 4'b0001; HLDA = 1'b0;
    tick(); chk("t_hrq_c1", {7'd0, hrq2}, 8'd1);
    tick(); chk("t_hrq_c2", {7'd0, hrq2}, 8'd1);
    tick(); chk("t_hrq_c3", {7'd0, hrq2}, 8'd1);
    tick(); chk("t_hrq_c4", {7'd0, hrq2}, 8'd1);
    tick(); chk("t_rel_hrq", {7'd0, hrq2}, 8'd0);
    chk("t_rel_busy", {7'd0, busy2}, 8'd1);
    tick(); chk("t_idle", {7'd0, busy2}, 8'd0);
    tick(); chk("t_rehrq", {7'd0, hrq2}, 8'd1);
    chk("t_forever", {7'd0, HRQ}, 8'd1);
    DREQ = 4'h0;
    tick(); chk("t_abandon", {7'd0, HRQ}, 8'd0);
    chk("t_abandon2", {7'd0, hrq2}, 8'd0);

    // Async reset mid-ACTIVE with pointer moved off zero
    COMMAND = 8'h10; HLDA = 1'b1; DREQ = 4'b0010;
    tick(); tick();
    chk("x_grant1", {6'd0, grant_ch}, 8'd1);
    TC = 1'b1;
    tick(); TC = 1'b0; DREQ = 4'b0100;
    tick(); tick();
    tick(); chk("x_dack2", {4'd0, DACK}, 8'b0100);
    #2; Reset_n = 1'b0;
    #1;
    chk("x_rst_dack", {4'd0, DACK}, 8'd0);
    chk("x_rst_hrq", {7'd0, HRQ}, 8'd0);
    chk("x_rst_busy", {7'd0, busy}, 8'd0);
    chk("x_rst_grant", {6'd0, grant_ch}, 8'd0);
    DREQ = 4'b1111;
    #1; Reset_n = 1'b1;
    tick(); chk("x_hrq", {7'd0, HRQ}, 8'd1);
    tick(); chk("x_first_grant", {6'd0, grant_ch}, 8'd0);
    chk("x_first_dack", {4'd0, DACK}, 8'b0001);
    DREQ = 4'h0; COMMAND = 8'h00; HLDA = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
